// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. A single full-adder slice is reused
// across WIDTH clocks, LSB first, with the carry held in a flop between bits.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' input for a - b.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry;
  logic [CW-1:0]    count;

  // operand values loaded on an accepted start
  logic [WIDTH-1:0] opb_ld;
  logic             carry_ld;

`ifdef SERIAL_ADD_SUB_EN
  // subtraction as a + ~b + 1; cin is ignored while subtracting
  assign opb_ld   = sub ? ~b : b;
  assign carry_ld = sub ? 1'b1 : cin;
`else
  assign opb_ld   = b;
  assign carry_ld = cin;
`endif

  // the shared full-adder slice
  logic s_bit, c_bit, last_bit, accept;
  assign s_bit    = opa[0] ^ opb[0] ^ carry;
  assign c_bit    = (opa[0] & opb[0]) | ((opa[0] ^ opb[0]) & carry);
  assign last_bit = (count == CW'(WIDTH - 1));
  assign accept   = start && (state == IDLE || state == DONE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: start is only honoured outside RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded straight from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // datapath: operand load, per-bit shift, result capture on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= opb_ld;
      carry <= carry_ld;
      count <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      acc   <= {s_bit, acc[WIDTH-1:1]};
      carry <= c_bit;
      count <= count + 1'b1;
      if (last_bit) begin
        sum  <= {s_bit, acc[WIDTH-1:1]};
        cout <= c_bit;
      end
    end
  end

endmodule
